alu_b_operand_sel: RTL and testbench

Parametrised, registered successor to the ALU operand-B source mux in the multicycle datapath. It selects one of six operand sources, including sign/zero extension and a left shift of the instruction immediate that it generates internally. The result is captured into an output register under a load strobe. It flags illegal select codes with a sticky error instead of producing an undefined output. It sits between the register file/instruction register and the ALU B input, driven by the control FSM.

---
 rtl/alu_b_operand_sel.sv | 102 ++++++++++
 tb/tb_alu_b_operand_sel.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_b_operand_sel.sv
// Registered ALU operand-B source select with sticky illegal-select reporting.
// Optional operand parity output enabled by defining ALU_B_PARITY_EN.
module alu_b_operand_sel #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned IMM_W   = 16,
    parameter int unsigned SHAMT   = 2,
    parameter int unsigned CONST_A = 4,
    parameter int unsigned CONST_B = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       sel,
    input  logic             load,
    input  logic [WIDTH-1:0] b_reg,
    input  logic [IMM_W-1:0] imm,
    input  logic             err_clr,
    output logic [WIDTH-1:0] operand,
    output logic             operand_vld,
    output logic             sel_err,
`ifdef ALU_B_PARITY_EN
    output logic             operand_par,
`endif
    output logic [2:0]       err_code
);

    typedef enum logic [2:0] {
        SRC_B_REG   = 3'b000,
        SRC_SEXT    = 3'b001,
        SRC_CONST_A = 3'b010,
        SRC_CONST_B = 3'b011,
        SRC_SEXT_SH = 3'b100,
        SRC_ZEXT    = 3'b101
    } src_e;

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] imm_shift;
    logic [WIDTH-1:0] src_value;
    logic             sel_legal;
    logic             legal_load;
    logic             illegal_load;

    // Size casts of a signed operand sign-extend, and stay legal when WIDTH == IMM_W.
    assign imm_sext  = WIDTH'($signed(imm));
    assign imm_zext  = WIDTH'(imm);
    assign imm_shift = imm_sext << SHAMT;

    always_comb begin
        src_value = '0;
        sel_legal = 1'b1;
        case (sel)
            SRC_B_REG:   src_value = b_reg;
            SRC_SEXT:    src_value = imm_sext;
            SRC_CONST_A: src_value = WIDTH'(CONST_A);
            SRC_CONST_B: src_value = WIDTH'(CONST_B);
            SRC_SEXT_SH: src_value = imm_shift;
            SRC_ZEXT:    src_value = imm_zext;
            default:     sel_legal = 1'b0;
        endcase
    end

    assign legal_load   = load & sel_legal;
    assign illegal_load = load & ~sel_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand     <= '0;
            operand_vld <= 1'b0;
        end else begin
            operand_vld <= legal_load;
            if (legal_load) begin
                operand <= src_value;
            end
        end
    end

`ifdef ALU_B_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand_par <= 1'b0;
        end else if (legal_load) begin
            operand_par <= ^src_value;
        end
    end
`endif

    // An illegal load in the same cycle as err_clr counts as a fresh first error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err  <= 1'b0;
            err_code <= '0;
        end else if (illegal_load) begin
            sel_err <= 1'b1;
            if (!sel_err || err_clr) begin
                err_code <= sel;
            end
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_b_operand_sel.sv
// Directed self-checking bench for alu_b_operand_sel (default parameters).
module tb_alu_b_operand_sel;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic        load;
    logic [31:0] b_reg;
    logic [15:0] imm;
    logic        err_clr;
    logic [31:0] operand;
    logic        operand_vld;
    logic        sel_err;
    logic [2:0]  err_code;
`ifdef ALU_B_PARITY_EN
    logic        operand_par;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_b_operand_sel #(
        .WIDTH(32), .IMM_W(16), .SHAMT(2), .CONST_A(4), .CONST_B(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .load(load),
        .b_reg(b_reg),
        .imm(imm),
        .err_clr(err_clr),
        .operand(operand),
        .operand_vld(operand_vld),
        .sel_err(sel_err),
`ifdef ALU_B_PARITY_EN
        .operand_par(operand_par),
`endif
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; sel = 3'b000; load = 1'b0; b_reg = '0; imm = '0; err_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_operand", operand, 32'h0);
        check("rst_vld", {31'b0, operand_vld}, 32'h0);
        check("rst_sel_err", {31'b0, sel_err}, 32'h0);
        check("rst_err_code", {29'b0, err_code}, 32'h0);

        // Source sweep, back-to-back loads
        load = 1'b1; sel = 3'b001; imm = 16'h8001;
        step();
        check("sext", operand, 32'hFFFF_8001);
        check("sext_vld", {31'b0, operand_vld}, 32'h1);
        sel = 3'b101;
        step();
        check("zext", operand, 32'h0000_8001);
        check("zext_vld", {31'b0, operand_vld}, 32'h1);
        sel = 3'b100;
        step();
        check("sext_shift", operand, 32'hFFFE_0004);
        sel = 3'b010;
        step();
        check("const_a", operand, 32'h0000_0004);
        sel = 3'b011;
        step();
        check("const_b", operand, 32'h0000_0001);
        sel = 3'b000; b_reg = 32'hDEAD_BEEF;
        step();
        check("b_reg", operand, 32'hDEAD_BEEF);
        check("b_reg_vld", {31'b0, operand_vld}, 32'h1);

        // Hold and single-cycle valid pulse
        b_reg = 32'h1111_1111;
        step();
        check("hold_load", operand, 32'h1111_1111);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = (i == 1) ? 3'b111 : 3'b000;
            b_reg = 32'hA5A5_0000 + i;
            step();
            check("hold_operand", operand, 32'h1111_1111);
            check("hold_vld", {31'b0, operand_vld}, 32'h0);
            check("hold_no_err", {31'b0, sel_err}, 32'h0);
        end

        // Illegal selects
        load = 1'b1; sel = 3'b010;
        step();
        check("pre_illegal", operand, 32'h4);
        sel = 3'b110;
        step();
        check("ill_operand", operand, 32'h4);
        check("ill_vld", {31'b0, operand_vld}, 32'h0);
        check("ill_sel_err", {31'b0, sel_err}, 32'h1);
        check("ill_code", {29'b0, err_code}, 32'h6);
        sel = 3'b111;
        step();
        check("ill2_code_kept", {29'b0, err_code}, 32'h6);
        check("ill2_vld", {31'b0, operand_vld}, 32'h0);
        sel = 3'b011;
        step();
        check("legal_after_err", operand, 32'h1);
        check("legal_after_err_vld", {31'b0, operand_vld}, 32'h1);
        check("err_still_set", {31'b0, sel_err}, 32'h1);

        // Clear versus set
        load = 1'b0; err_clr = 1'b1;
        step();
        check("clr_sel_err", {31'b0, sel_err}, 32'h0);
        check("clr_code_kept", {29'b0, err_code}, 32'h6);
        load = 1'b1; sel = 3'b111; err_clr = 1'b1;
        step();
        check("clr_set_err", {31'b0, sel_err}, 32'h1);
        check("clr_set_code", {29'b0, err_code}, 32'h7);
        err_clr = 1'b0; sel = 3'b110;
        step();
        check("sticky_code", {29'b0, err_code}, 32'h7);
        err_clr = 1'b1; sel = 3'b110;
        step();
        check("recapture_err", {31'b0, sel_err}, 32'h1);
        check("recapture_code", {29'b0, err_code}, 32'h6);
        err_clr = 1'b0;

        // Asynchronous reset mid-operation
        sel = 3'b000; b_reg = 32'h1234_5678;
        step();
        check("pre_reset", operand, 32'h1234_5678);
        load = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_operand", operand, 32'h0);
        check("async_vld", {31'b0, operand_vld}, 32'h0);
        check("async_sel_err", {31'b0, sel_err}, 32'h0);
        check("async_code", {29'b0, err_code}, 32'h0);
        step();
        reset = 1'b0;
        load = 1'b1; sel = 3'b101; imm = 16'h7FFF;
        step();
        check("post_reset_load", operand, 32'h0000_7FFF);
        check("post_reset_vld", {31'b0, operand_vld}, 32'h1);
        check("post_reset_err", {31'b0, sel_err}, 32'h0);

`ifdef ALU_B_PARITY_EN
        sel = 3'b000; b_reg = 32'h0000_0007;
        step();
        check("par_odd", {31'b0, operand_par}, 32'h1);
        b_reg = 32'h0000_0003;
        step();
        check("par_even", {31'b0, operand_par}, 32'h0);
        b_reg = 32'h0000_0001; load = 1'b0;
        step();
        check("par_hold", {31'b0, operand_par}, 32'h0);
`endif

        load = 1'b0;
        step();
        check("final_vld_drop", {31'b0, operand_vld}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
